// File: rtl/imu_quat_integrator.sv
// imu_quat_integrator
// Integrates body angular rates into an attitude quaternion, one sample at a
// time: q <- q + 0.5 * Omega(w*dt) * q, with saturation to Q1.(DW-1).
// A single shared DW x DW multiplier is time-multiplexed over 12 cycles.
module imu_quat_integrator #(
   parameter int DW    = 16,
   parameter int DTW   = 32,
   parameter int SHIFT = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] wx,
   input  logic signed [DW-1:0] wy,
   input  logic signed [DW-1:0] wz,
   input  logic [DTW-1:0]       dt,
   input  logic                 q_load,
   input  logic signed [DW-1:0] q_init0,
   input  logic signed [DW-1:0] q_init1,
   input  logic signed [DW-1:0] q_init2,
   input  logic signed [DW-1:0] q_init3,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] q0,
   output logic signed [DW-1:0] q1,
   output logic signed [DW-1:0] q2,
   output logic signed [DW-1:0] q3,
   output logic                 sat_flag
);

   // Width of the rate*dt product, of the quaternion accumulators and of
   // the update sum (one extra bit so q + delta never wraps before clipping).
   localparam int PW = DW + DTW + 1;
   localparam int AW = 2 * DW + 2;
   localparam int UW = AW + 1;

   localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SCALE = 3'd1,
      S_MUL   = 3'd2,
      S_UPD   = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic signed [DW-1:0] w_q   [3];
   logic signed [DW-1:0] w_d   [3];
   logic [DTW-1:0]       dt_q, dt_d;
   logic signed [DW-1:0] d_q   [3];
   logic signed [DW-1:0] d_d   [3];
   logic signed [AW-1:0] acc_q [4];
   logic signed [AW-1:0] acc_d [4];
   logic signed [DW-1:0] q_q   [4];
   logic signed [DW-1:0] q_d   [4];
   logic                 out_valid_q, out_valid_d;
   logic                 sat_q, sat_d;

   // ------------------------------------------------------------------
   // SCALE datapath: d_i = sat((w_i * dt) >>> (SHIFT+1)), dt treated unsigned
   // ------------------------------------------------------------------
   logic signed [DW-1:0] w_sel;
   logic signed [PW-1:0] sc_w_ext, sc_dt_ext, sc_prod, sc_shift;
   logic [PW-DW:0]       sc_hi;
   logic                 sc_clip;
   logic signed [DW-1:0] sc_val;

   // Pick the rate component addressed by the SCALE step counter.
   always_comb begin
      w_sel = w_q[0];
      case (cnt_q)
         4'd1:    w_sel = w_q[1];
         4'd2:    w_sel = w_q[2];
         default: w_sel = w_q[0];
      endcase
   end

   assign sc_w_ext  = {{(DTW+1){w_sel[DW-1]}}, w_sel};
   assign sc_dt_ext = {{DW{1'b0}}, dt_q};
   assign sc_prod   = sc_w_ext * sc_dt_ext;
   assign sc_shift  = sc_prod >>> (SHIFT + 1);
   // The value fits in DW bits only if every bit from DW-1 upward matches.
   assign sc_hi     = sc_shift[PW-1:DW-1];
   assign sc_clip   = !((&sc_hi) || (~|sc_hi));
   assign sc_val    = sc_clip ? (sc_shift[PW-1] ? MINV : MAXV) : sc_shift[DW-1:0];

   // ------------------------------------------------------------------
   // MUL datapath: one signed DW x DW product per cycle, routed into one of
   // the four accumulators with an add or subtract.
   // ------------------------------------------------------------------
   logic signed [DW-1:0]   mul_a, mul_b;
   logic                   mul_neg;
   logic [1:0]             mul_idx;
   logic signed [2*DW-1:0] mul_a_ext, mul_b_ext, mul_p;
   logic signed [AW-1:0]   mul_ext;

   // Product schedule: steps 0-2 feed s0, 3-5 s1, 6-8 s2, 9-11 s3.
   always_comb begin
      mul_a   = q_q[1];
      mul_b   = d_q[0];
      mul_neg = 1'b1;
      mul_idx = 2'd0;
      case (cnt_q)
         4'd0:  begin mul_a = q_q[1]; mul_b = d_q[0]; mul_neg = 1'b1; mul_idx = 2'd0; end
         4'd1:  begin mul_a = q_q[2]; mul_b = d_q[1]; mul_neg = 1'b1; mul_idx = 2'd0; end
         4'd2:  begin mul_a = q_q[3]; mul_b = d_q[2]; mul_neg = 1'b1; mul_idx = 2'd0; end
         4'd3:  begin mul_a = q_q[0]; mul_b = d_q[0]; mul_neg = 1'b0; mul_idx = 2'd1; end
         4'd4:  begin mul_a = q_q[2]; mul_b = d_q[2]; mul_neg = 1'b0; mul_idx = 2'd1; end
         4'd5:  begin mul_a = q_q[3]; mul_b = d_q[1]; mul_neg = 1'b1; mul_idx = 2'd1; end
         4'd6:  begin mul_a = q_q[0]; mul_b = d_q[1]; mul_neg = 1'b0; mul_idx = 2'd2; end
         4'd7:  begin mul_a = q_q[1]; mul_b = d_q[2]; mul_neg = 1'b1; mul_idx = 2'd2; end
         4'd8:  begin mul_a = q_q[3]; mul_b = d_q[0]; mul_neg = 1'b0; mul_idx = 2'd2; end
         4'd9:  begin mul_a = q_q[0]; mul_b = d_q[2]; mul_neg = 1'b0; mul_idx = 2'd3; end
         4'd10: begin mul_a = q_q[1]; mul_b = d_q[1]; mul_neg = 1'b0; mul_idx = 2'd3; end
         4'd11: begin mul_a = q_q[2]; mul_b = d_q[0]; mul_neg = 1'b1; mul_idx = 2'd3; end
         default: begin mul_a = q_q[1]; mul_b = d_q[0]; mul_neg = 1'b1; mul_idx = 2'd0; end
      endcase
   end

   assign mul_a_ext = {{DW{mul_a[DW-1]}}, mul_a};
   assign mul_b_ext = {{DW{mul_b[DW-1]}}, mul_b};
   assign mul_p     = mul_a_ext * mul_b_ext;
   assign mul_ext   = {{2{mul_p[2*DW-1]}}, mul_p};

   // ------------------------------------------------------------------
   // UPD datapath: q_i + floor(s_i / 2^(DW-1)), clipped to the DW range.
   // ------------------------------------------------------------------
   logic signed [DW-1:0] upd_val  [4];
   logic [3:0]           upd_clip;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_upd
         logic signed [AW-1:0] acc_sh;
         logic [UW-1:0]        upd_sum;
         logic [UW-DW:0]       upd_hi;

         assign acc_sh       = acc_q[gi] >>> (DW - 1);
         assign upd_sum      = {{(UW-DW){q_q[gi][DW-1]}}, q_q[gi]} + {acc_sh[AW-1], acc_sh};
         assign upd_hi       = upd_sum[UW-1:DW-1];
         assign upd_clip[gi] = !((&upd_hi) || (~|upd_hi));
         assign upd_val[gi]  = upd_clip[gi] ? (upd_sum[UW-1] ? MINV : MAXV)
                                            : upd_sum[DW-1:0];
      end
   endgenerate

   // Next-state and datapath-update logic for every register in the block.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      w_d         = w_q;
      dt_d        = dt_q;
      d_d         = d_q;
      acc_d       = acc_q;
      q_d         = q_q;
      out_valid_d = out_valid_q;
      sat_d       = sat_q;

      case (state_q)
         S_IDLE: begin
            if (q_load) begin
               q_d[0] = q_init0;
               q_d[1] = q_init1;
               q_d[2] = q_init2;
               q_d[3] = q_init3;
            end else if (in_valid) begin
               w_d[0] = wx;
               w_d[1] = wy;
               w_d[2] = wz;
               dt_d   = dt;
               cnt_d  = 4'd0;
               for (int i = 0; i < 4; i++) acc_d[i] = '0;
               state_d = S_SCALE;
            end
         end
         S_SCALE: begin
            for (int i = 0; i < 3; i++) begin
               if (cnt_q == 4'(i)) d_d[i] = sc_val;
            end
            if (sc_clip) sat_d = 1'b1;
            if (cnt_q == 4'd2) begin
               cnt_d   = 4'd0;
               state_d = S_MUL;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_MUL: begin
            acc_d[mul_idx] = mul_neg ? (acc_q[mul_idx] - mul_ext)
                                     : (acc_q[mul_idx] + mul_ext);
            if (cnt_q == 4'd11) begin
               cnt_d   = 4'd0;
               state_d = S_UPD;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_UPD: begin
            for (int i = 0; i < 4; i++) q_d[i] = upd_val[i];
            if (|upd_clip) sat_d = 1'b1;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any computation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         dt_q        <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            w_q[i] <= '0;
            d_q[i] <= '0;
         end
         for (int i = 0; i < 4; i++) acc_q[i] <= '0;
         q_q[0] <= MAXV;
         q_q[1] <= '0;
         q_q[2] <= '0;
         q_q[3] <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dt_q        <= dt_d;
         out_valid_q <= out_valid_d;
         sat_q       <= sat_d;
         w_q         <= w_d;
         d_q         <= d_d;
         acc_q       <= acc_d;
         q_q         <= q_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign sat_flag  = sat_q;
   assign q0        = q_q[0];
   assign q1        = q_q[1];
   assign q2        = q_q[2];
   assign q3        = q_q[3];

endmodule

// File: tb/tb_imu_quat_integrator.sv
// Directed bench for imu_quat_integrator with hand-computed expected values.
module tb_imu_quat_integrator;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] wx, wy, wz;
   logic [31:0]        dt;
   logic               q_load;
   logic signed [15:0] q_init0, q_init1, q_init2, q_init3;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] q0, q1, q2, q3;
   logic               sat_flag;

   int total = 0;
   int bad   = 0;

   imu_quat_integrator #(.DW(16), .DTW(32), .SHIFT(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .wx        (wx),
      .wy        (wy),
      .wz        (wz),
      .dt        (dt),
      .q_load    (q_load),
      .q_init0   (q_init0),
      .q_init1   (q_init1),
      .q_init2   (q_init2),
      .q_init3   (q_init3),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q0        (q0),
      .q1        (q1),
      .q2        (q2),
      .q3        (q3),
      .sat_flag  (sat_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic check_q(input string tag, input longint e0, input longint e1,
                          input longint e2, input longint e3);
      check_val({tag, ".q0"}, q0, e0);
      check_val({tag, ".q1"}, q1, e1);
      check_val({tag, ".q2"}, q2, e2);
      check_val({tag, ".q3"}, q3, e3);
   endtask

   // Load a quaternion while idle (called at posedge+1).
   task automatic load_q(input int a, input int b, input int c, input int d);
      q_load  = 1'b1;
      q_init0 = 16'(a);
      q_init1 = 16'(b);
      q_init2 = 16'(c);
      q_init3 = 16'(d);
      @(posedge clk); #1;
      q_load = 1'b0;
   endtask

   // Present one sample, scramble inputs after acceptance, then measure the
   // latency to out_valid with a bounded wait.
   task automatic send(input string tag, input int ax, input int ay, input int az,
                       input logic [31:0] adt);
      int lat;
      in_valid = 1'b1;
      wx = 16'(ax);
      wy = 16'(ay);
      wz = 16'(az);
      dt = adt;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wx = 16'sh7abc;
      wy = -16'sd1234;
      wz = 16'sh4321;
      dt = 32'hFFFF_FFFF;
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = n;
            break;
         end
      end
      check_val({tag, ".latency"}, lat, 16);
   endtask

   // Single-cycle out_ready pulse, then confirm the handshake completed.
   task automatic release_out(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_val({tag, ".ovalid_clr"}, out_valid, 0);
      check_val({tag, ".in_ready"}, in_ready, 1);
   endtask

   initial begin
      int seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      q_load    = 1'b0;
      out_ready = 1'b0;
      wx = '0; wy = '0; wz = '0; dt = '0;
      q_init0 = '0; q_init1 = '0; q_init2 = '0; q_init3 = '0;

      // Reset state
      #12;
      check_q("reset", 32767, 0, 0, 0);
      check_val("reset.out_valid", out_valid, 0);
      check_val("reset.sat_flag", sat_flag, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_val("reset.in_ready", in_ready, 1);

      // Zero rates
      send("zero", 0, 0, 0, 32'd65536);
      check_q("zero", 32767, 0, 0, 0);
      check_val("zero.sat", sat_flag, 0);
      release_out("zero");

      // Small positive x rotation
      send("xpos", 16384, 0, 0, 32'd65536);
      check_q("xpos", 32767, 8191, 0, 0);
      check_val("xpos.sat", sat_flag, 0);
      release_out("xpos");

      // Negative x rotation: floor rounding toward -inf
      load_q(32767, 0, 0, 0);
      send("xneg", -16384, 0, 0, 32'd65536);
      check_q("xneg", 32767, -8192, 0, 0);
      release_out("xneg");

      // Load priority over in_valid
      q_load   = 1'b1;
      in_valid = 1'b1;
      q_init0 = 16'sd0; q_init1 = 16'sd32767; q_init2 = 16'sd0; q_init3 = 16'sd0;
      wx = 16'sd16384; wy = 16'sd0; wz = 16'sd0; dt = 32'd65536;
      @(posedge clk); #1;
      q_load   = 1'b0;
      in_valid = 1'b0;
      check_q("loadpri", 0, 32767, 0, 0);
      check_val("loadpri.in_ready", in_ready, 1);
      seen = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check_val("loadpri.no_out", seen, 0);

      // y rotation from q=(0,32767,0,0): exercises s3
      send("yrot", 0, 16384, 0, 32'd65536);
      check_q("yrot", 0, 32767, 0, 8191);
      release_out("yrot");

      // negative z rotation: exercises s0 and s2 with mixed signs
      send("zneg", 0, 0, -16384, 32'd65536);
      check_q("zneg", 2047, 32767, 8191, 8191);
      release_out("zneg");

      // Saturation of dx, sticky flag
      load_q(32767, 0, 0, 0);
      send("sat", 32767, 0, 0, 32'hFFFF_FFFF);
      check_q("sat", 32767, 32766, 0, 0);
      check_val("sat.flag", sat_flag, 1);
      release_out("sat");
      send("sat_zero", 0, 0, 0, 32'd65536);
      check_q("sat_zero", 32767, 32766, 0, 0);
      check_val("sat_zero.flag", sat_flag, 1);

      // Backpressure: held in OUT; in_valid/q_load ignored there
      in_valid = 1'b1;
      q_load   = 1'b1;
      q_init0 = 16'sd1; q_init1 = 16'sd2; q_init2 = 16'sd3; q_init3 = 16'sd4;
      wx = 16'sd16384;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         check_val("bp.out_valid", out_valid, 1);
         check_val("bp.in_ready", in_ready, 0);
         check_val("bp.q1", q1, 32766);
         check_val("bp.q0", q0, 32767);
      end
      in_valid = 1'b0;
      q_load   = 1'b0;
      release_out("bp");
      check_q("bp.after", 32767, 32766, 0, 0);

      // Reset mid-MUL from a non-identity attitude
      load_q(0, 32767, 0, 0);
      in_valid = 1'b1;
      wx = 16'sd16384; wy = 16'sd0; wz = 16'sd0; dt = 32'd65536;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int n = 0; n < 8; n++) @(posedge clk);
      #1;
      check_val("midmul.busy", in_ready, 0);
      rst_n = 1'b0;
      #1;
      check_q("midmul.rst", 32767, 0, 0, 0);
      check_val("midmul.out_valid", out_valid, 0);
      check_val("midmul.sat", sat_flag, 0);
      #5;
      rst_n = 1'b1;
      seen = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check_val("midmul.no_out", seen, 0);
      check_val("midmul.in_ready", in_ready, 1);
      check_q("midmul.final", 32767, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imu_quat_integrator.md
IMU_QUAT_INTEGRATOR -- requirements
Module: imu_quat_integrator

Interface
REQ-001 SHALL have parameter DW, default 16: width of rates and quaternion components, format Q1.(DW-1).
REQ-002 SHALL have parameter DTW, default 32: width of unsigned timestep dt.
REQ-003 SHALL have parameter SHIFT, default 16: dt scaling shift, so that w*dt >>> SHIFT is a rate-times-time angle in Q1.(DW-1).
REQ-004 SHALL have port clk  input  1  single clock, rising-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  sample valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a sample.
REQ-008 SHALL have port wx, wy, wz  input  DW each  signed angular rates.
REQ-009 SHALL have port dt  input  DTW  unsigned timestep.
REQ-010 SHALL have port q_load  input  1  load the initial quaternion (sampled in IDLE only).
REQ-011 SHALL have port q_init0..q_init3  input  DW each  signed initial quaternion.
REQ-012 SHALL have port out_valid  output  1  updated quaternion available.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the output.
REQ-014 SHALL have port q0..q3  output  DW each  signed current attitude quaternion.
REQ-015 SHALL have port sat_flag  output  1  sticky: saturation has occurred.

Function
REQ-016 SHALL implement FSM states IDLE, SCALE, MUL, UPD, OUT; in_ready = 1 only in IDLE.
REQ-017 In IDLE, if q_load = 1, SHALL load q0..q3 from q_init0..q_init3 and stay in IDLE; q_load takes priority over a simultaneous in_valid, which is not accepted that cycle.
REQ-018 In IDLE, if in_valid = 1 and q_load = 0, SHALL capture wx, wy, wz and dt and go to SCALE.
REQ-019 SCALE SHALL last 3 cycles, one product per cycle: d_i = (w_i * dt) >>> (SHIFT+1), with the signed product at full DW+DTW+1 width.
REQ-020 Each d_i SHALL saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-021 MUL SHALL last 12 cycles using one shared signed DW x DW multiplier; products SHALL accumulate at full 2*DW+2 width, with no intermediate truncation.
REQ-022 The four sums SHALL be:
  - s0 = -(q1*dx + q2*dy + q3*dz)
  - s1 = q0*dx + q2*dz - q3*dy
  - s2 = q0*dy - q1*dz + q3*dx
  - s3 = q0*dz + q1*dy - q2*dx
REQ-023 UPD (1 cycle) SHALL set qi <= sat(qi + (si >>> (DW-1))), where >>> truncates toward negative infinity and sat uses the REQ-020 range; it SHALL assert out_valid and go to OUT.
REQ-024 Latency: out_valid SHALL rise on the 16th rising edge after the edge that accepted the input.
REQ-025 In OUT, q0..q3 and out_valid SHALL hold stable while out_ready = 0; on out_valid & out_ready the block SHALL clear out_valid and go to IDLE.
REQ-026 in_valid and q_load SHALL be ignored outside IDLE.
REQ-027 q0..q3 SHALL change only in UPD, on q_load in IDLE, or on reset.
REQ-028 sat_flag SHALL set when any saturation in REQ-020 or REQ-023 clips a value; it clears only on reset.
REQ-029 Inputs captured in REQ-018 SHALL be used for the whole computation; later input changes have no effect.

Reset
REQ-030 When rst_n = 0, immediately, independent of clk, the block SHALL set: state IDLE, q0 = 2^(DW-1)-1, q1 = q2 = q3 = 0, out_valid = 0, sat_flag = 0, accumulators = 0.
REQ-031 Reset mid-computation SHALL abandon that computation; nothing is output for it after release.
REQ-032 in_ready SHALL be 1 from the first rising edge after rst_n deasserts.

Verification (DW=16, DTW=32, SHIFT=16)
REQ-033 Zero rates: wx=wy=wz=0, dt=65536 -> 16 cycles later out_valid=1; q = (32767, 0, 0, 0); sat_flag=0.
REQ-034 Small x rotation: wx=16384, wy=wz=0, dt=65536 -> dx=8192; q = (32767, 8191, 0, 0).
REQ-035 Saturation: wx=32767, dt=0xFFFFFFFF -> dx clipped to 32767; q1=32766; sat_flag=1 and stays 1 after subsequent zero-rate samples.
REQ-036 Backpressure: out_ready held 0 for 10 cycles -> q and out_valid stable and in_ready=0 throughout; one out_ready pulse -> IDLE next cycle.
REQ-037 Load priority: q_load=1 with in_valid=1 and q_init=(0, 32767, 0, 0) in IDLE -> q loaded, sample not accepted, no out_valid.
REQ-038 Reset mid-MUL: rst_n low at cycle 8 after accept -> q = (32767, 0, 0, 0), out_valid=0, and no out_valid appears after release.
